// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the two-motor PWM command sequencer.
package pwm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RAMP  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DECEL = 3'd3,
      ST_COAST = 3'd4
   } motor_state_t;

   localparam logic MOTOR_A = 1'b0;
   localparam logic MOTOR_B = 1'b1;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // A motor is busy whenever its duty is moving or a reversal is in flight.
   function automatic logic state_is_busy(input motor_state_t s);
      return !((s == ST_IDLE) || (s == ST_HOLD));
   endfunction

endpackage

// File: rtl/motor_ramp_fsm.sv
// Per-motor duty slew controller: ramps cur toward tgt one step per tick and
// sequences direction reversals through decelerate-to-zero and a coast interval.
module motor_ramp_fsm
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_WIDTH  = 16,
   parameter int unsigned RAMP_STEP   = 64,
   parameter int unsigned COAST_TICKS = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_tick,
   input  logic                  i_accept,
   input  logic                  i_dir,
   input  logic [DUTY_WIDTH-1:0] i_duty,
   input  logic                  i_fault,
   output logic [DUTY_WIDTH-1:0] o_cur,
   output logic                  o_dir,
   output motor_state_t          o_state,
   output logic                  o_busy,
   output logic                  o_at_target
);

   localparam int unsigned           CW       = $clog2(COAST_TICKS + 1);
   localparam logic [DUTY_WIDTH-1:0] LP_STEP  = DUTY_WIDTH'(RAMP_STEP);
   localparam logic [CW-1:0]         LP_COAST = CW'(COAST_TICKS);
   localparam logic [CW-1:0]         LP_ONE   = CW'(1);

   motor_state_t          r_state;
   logic [DUTY_WIDTH-1:0] r_cur;
   logic [DUTY_WIDTH-1:0] r_tgt;
   logic                  r_dir;
   logic                  r_pend;
   logic [CW-1:0]         r_coast;

   motor_state_t          w_state_nxt;
   logic [DUTY_WIDTH-1:0] w_cur_nxt;
   logic [DUTY_WIDTH-1:0] w_tgt_nxt;
   logic                  w_dir_nxt;
   logic                  w_pend_nxt;
   logic [CW-1:0]         w_coast_nxt;
   logic                  w_up;
   logic [DUTY_WIDTH-1:0] w_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_tgt   <= '0;
         r_dir   <= DIR_FWD;
         r_pend  <= DIR_FWD;
         r_coast <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_tgt   <= w_tgt_nxt;
         r_dir   <= w_dir_nxt;
         r_pend  <= w_pend_nxt;
         r_coast <= w_coast_nxt;
      end
   end

   // Tick work uses the old target; an accepted command then overrides the
   // target and state, deciding decel vs. coast on the post-tick duty.
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_tgt_nxt   = r_tgt;
      w_dir_nxt   = r_dir;
      w_pend_nxt  = r_pend;
      w_coast_nxt = r_coast;
      w_up        = (r_tgt >= r_cur);
      w_diff      = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);

      if (i_tick) begin
         case (r_state)
            ST_RAMP: begin
               if (w_diff <= LP_STEP) begin
                  w_cur_nxt   = r_tgt;
                  w_state_nxt = (r_tgt == '0) ? ST_IDLE : ST_HOLD;
               end else begin
                  w_cur_nxt = w_up ? (r_cur + LP_STEP) : (r_cur - LP_STEP);
               end
            end
            ST_DECEL: begin
               if (r_cur <= LP_STEP) begin
                  w_cur_nxt   = '0;
                  w_coast_nxt = LP_COAST;
                  w_state_nxt = ST_COAST;
               end else begin
                  w_cur_nxt = r_cur - LP_STEP;
               end
            end
            ST_COAST: begin
               w_cur_nxt = '0;
               if (r_coast <= LP_ONE) begin
                  w_coast_nxt = '0;
                  w_dir_nxt   = r_pend;
                  w_state_nxt = (r_tgt != '0) ? ST_RAMP : ST_IDLE;
               end else begin
                  w_coast_nxt = r_coast - LP_ONE;
               end
            end
            default: ;
         endcase
      end

      if (i_accept) begin
         w_tgt_nxt  = i_duty;
         w_pend_nxt = i_dir;
         if (i_dir == r_dir) begin
            w_state_nxt = ST_RAMP;
         end else if (w_cur_nxt != '0) begin
            w_state_nxt = ST_DECEL;
         end else begin
            w_cur_nxt   = '0;
            w_coast_nxt = LP_COAST;
            w_state_nxt = ST_COAST;
         end
      end

      if (i_fault) begin
         w_state_nxt = ST_IDLE;
         w_cur_nxt   = '0;
         w_tgt_nxt   = '0;
         w_dir_nxt   = r_dir;
         w_pend_nxt  = r_dir;
         w_coast_nxt = '0;
      end
   end

   always_comb begin
      o_cur       = r_cur;
      o_dir       = r_dir;
      o_state     = r_state;
      o_busy      = state_is_busy(r_state);
      o_at_target = (r_cur == r_tgt);
   end

endmodule

// File: rtl/pwm_motor_sequencer.sv
// Command-level front end for the PWM generator: two H-bridge motor pairs with
// slew-limited duty, safe reversals, gated frequency changes and a latched e-stop.
module pwm_motor_sequencer
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned           DUTY_WIDTH   = 16,
   parameter int unsigned           STEP_DIV     = 50000,
   parameter int unsigned           RAMP_STEP    = 64,
   parameter int unsigned           COAST_TICKS  = 20,
   parameter logic [DUTY_WIDTH-1:0] MAX_DUTY     = 16'hFFFF,
   parameter logic [31:0]           DEFAULT_FREQ = 32'd20000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_motor,
   input  logic                  cmd_dir,
   input  logic [DUTY_WIDTH-1:0] cmd_duty,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [31:0]           cfg_frequency,
   input  logic                  emergency_stop,
   input  logic                  fault_clear,
   output logic [DUTY_WIDTH-1:0] duty_cycle_0,
   output logic [DUTY_WIDTH-1:0] duty_cycle_1,
   output logic [DUTY_WIDTH-1:0] duty_cycle_2,
   output logic [DUTY_WIDTH-1:0] duty_cycle_3,
   output logic                  enable_0,
   output logic                  enable_1,
   output logic                  enable_2,
   output logic                  enable_3,
   output logic                  hbridge_mode_01,
   output logic                  hbridge_mode_23,
   output logic [31:0]           pwm_frequency,
   output logic                  update_config,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic                  at_target_a,
   output logic                  at_target_b,
   output logic                  fault,
   output motor_state_t          dbg_state_a,
   output motor_state_t          dbg_state_b
);

   localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [PW-1:0]         r_presc;
   logic                  r_fault;
   logic [31:0]           r_freq;
   logic                  r_update;

   logic                  w_tick;
   logic                  w_fault_any;
   logic [DUTY_WIDTH-1:0] w_duty_sat;
   motor_state_t          w_sel_state;
   logic                  w_cmd_accept;
   logic                  w_accept_a;
   logic                  w_accept_b;
   logic                  w_cfg_accept;

   logic [DUTY_WIDTH-1:0] w_cur_a;
   logic [DUTY_WIDTH-1:0] w_cur_b;
   logic                  w_dir_a;
   logic                  w_dir_b;
   motor_state_t          w_state_a;
   motor_state_t          w_state_b;
   logic                  w_busy_a;
   logic                  w_busy_b;
   logic                  w_at_tgt_a;
   logic                  w_at_tgt_b;

   assign w_tick = (r_presc == PW'(STEP_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault <= 1'b0;
      end else if (emergency_stop) begin
         r_fault <= 1'b1;
      end else if (fault_clear) begin
         r_fault <= 1'b0;
      end
   end

   // The raw stop input clears the motors in the same edge it is first seen.
   assign w_fault_any = r_fault | emergency_stop;

   // Handshakes: a transfer happens on every clock edge where valid and ready
   // are both high; ready never depends on valid, and valid may drop freely.
   assign w_sel_state  = (cmd_motor == MOTOR_B) ? w_state_b : w_state_a;
   assign cmd_ready    = !r_fault && !emergency_stop && (w_sel_state != ST_COAST);
   assign w_cmd_accept = cmd_valid && cmd_ready;
   assign w_accept_a   = w_cmd_accept && (cmd_motor == MOTOR_A);
   assign w_accept_b   = w_cmd_accept && (cmd_motor == MOTOR_B);
   assign w_duty_sat   = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;

   assign cfg_ready    = !r_fault && (w_state_a == ST_IDLE) && (w_state_b == ST_IDLE);
   assign w_cfg_accept = cfg_valid && cfg_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_freq   <= DEFAULT_FREQ;
         r_update <= 1'b0;
      end else begin
         r_update <= w_cfg_accept;
         if (w_cfg_accept) begin
            r_freq <= cfg_frequency;
         end
      end
   end

   motor_ramp_fsm #(
      .DUTY_WIDTH  (DUTY_WIDTH),
      .RAMP_STEP   (RAMP_STEP),
      .COAST_TICKS (COAST_TICKS)
   ) u_motor_a (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (w_tick),
      .i_accept    (w_accept_a),
      .i_dir       (cmd_dir),
      .i_duty      (w_duty_sat),
      .i_fault     (w_fault_any),
      .o_cur       (w_cur_a),
      .o_dir       (w_dir_a),
      .o_state     (w_state_a),
      .o_busy      (w_busy_a),
      .o_at_target (w_at_tgt_a)
   );

   motor_ramp_fsm #(
      .DUTY_WIDTH  (DUTY_WIDTH),
      .RAMP_STEP   (RAMP_STEP),
      .COAST_TICKS (COAST_TICKS)
   ) u_motor_b (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (w_tick),
      .i_accept    (w_accept_b),
      .i_dir       (cmd_dir),
      .i_duty      (w_duty_sat),
      .i_fault     (w_fault_any),
      .o_cur       (w_cur_b),
      .o_dir       (w_dir_b),
      .o_state     (w_state_b),
      .o_busy      (w_busy_b),
      .o_at_target (w_at_tgt_b)
   );

   // Only the half-bridge selected by dir is driven; the other stays off.
   always_comb begin
      duty_cycle_0 = (w_dir_a == DIR_FWD) ? w_cur_a : '0;
      duty_cycle_1 = (w_dir_a == DIR_REV) ? w_cur_a : '0;
      duty_cycle_2 = (w_dir_b == DIR_FWD) ? w_cur_b : '0;
      duty_cycle_3 = (w_dir_b == DIR_REV) ? w_cur_b : '0;
      enable_0     = (w_dir_a == DIR_FWD) && (w_cur_a != '0);
      enable_1     = (w_dir_a == DIR_REV) && (w_cur_a != '0);
      enable_2     = (w_dir_b == DIR_FWD) && (w_cur_b != '0);
      enable_3     = (w_dir_b == DIR_REV) && (w_cur_b != '0);
   end

   assign hbridge_mode_01 = 1'b1;
   assign hbridge_mode_23 = 1'b1;
   assign pwm_frequency   = r_freq;
   assign update_config   = r_update;
   assign busy_a          = w_busy_a;
   assign busy_b          = w_busy_b;
   assign at_target_a     = w_at_tgt_a;
   assign at_target_b     = w_at_tgt_b;
   assign fault           = r_fault;
   assign dbg_state_a     = w_state_a;
   assign dbg_state_b     = w_state_b;

endmodule

// File: tb/tb_pwm_motor_sequencer.sv
// Directed bench for pwm_motor_sequencer: ramps, reversal, config gating,
// e-stop, saturation/tick coincidence and mid-operation reset.
module tb_pwm_motor_sequencer;
   import pwm_ctrl_pkg::*;

   localparam int DW          = 16;
   localparam int STEP_DIV    = 4;
   localparam int RAMP_STEP   = 100;
   localparam int COAST_TICKS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_motor;
   logic          cmd_dir;
   logic [DW-1:0] cmd_duty;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [31:0]   cfg_frequency;
   logic          emergency_stop;
   logic          fault_clear;
   logic [DW-1:0] duty_cycle_0, duty_cycle_1, duty_cycle_2, duty_cycle_3;
   logic          enable_0, enable_1, enable_2, enable_3;
   logic          hbridge_mode_01, hbridge_mode_23;
   logic [31:0]   pwm_frequency;
   logic          update_config;
   logic          busy_a, busy_b, at_target_a, at_target_b, fault;
   motor_state_t  dbg_state_a, dbg_state_b;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            m_presc = 0;
   logic [DW-1:0] exp_q[$];

   pwm_motor_sequencer #(
      .DUTY_WIDTH   (DW),
      .STEP_DIV     (STEP_DIV),
      .RAMP_STEP    (RAMP_STEP),
      .COAST_TICKS  (COAST_TICKS),
      .MAX_DUTY     (16'd1000),
      .DEFAULT_FREQ (32'd20000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_motor       (cmd_motor),
      .cmd_dir         (cmd_dir),
      .cmd_duty        (cmd_duty),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_frequency   (cfg_frequency),
      .emergency_stop  (emergency_stop),
      .fault_clear     (fault_clear),
      .duty_cycle_0    (duty_cycle_0),
      .duty_cycle_1    (duty_cycle_1),
      .duty_cycle_2    (duty_cycle_2),
      .duty_cycle_3    (duty_cycle_3),
      .enable_0        (enable_0),
      .enable_1        (enable_1),
      .enable_2        (enable_2),
      .enable_3        (enable_3),
      .hbridge_mode_01 (hbridge_mode_01),
      .hbridge_mode_23 (hbridge_mode_23),
      .pwm_frequency   (pwm_frequency),
      .update_config   (update_config),
      .busy_a          (busy_a),
      .busy_b          (busy_b),
      .at_target_a     (at_target_a),
      .at_target_b     (at_target_b),
      .fault           (fault),
      .dbg_state_a     (dbg_state_a),
      .dbg_state_b     (dbg_state_b)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Tick reference: the edge that leaves m_presc at 0 is a ramp tick.
   always @(posedge clk) begin
      if (rst) m_presc <= 0;
      else     m_presc <= (m_presc == STEP_DIV - 1) ? 0 : m_presc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int k = 0;
      do begin
         step();
         k++;
      end while (m_presc != 0 && k < 2 * STEP_DIV);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: observed %0d expected <none queued>", tag, obs);
      end else begin
         check(tag, obs, 32'(exp_q.pop_front()));
      end
   endtask

   task automatic send_cmd(input logic m, input logic d, input logic [DW-1:0] duty);
      cmd_motor = m;
      cmd_dir   = d;
      cmd_duty  = duty;
      cmd_valid = 1'b1;
      #1;
      check("cmd_ready_before_send", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_duty0"}, duty_cycle_0, 0);
      check({tag, "_duty1"}, duty_cycle_1, 0);
      check({tag, "_duty2"}, duty_cycle_2, 0);
      check({tag, "_duty3"}, duty_cycle_3, 0);
      check({tag, "_enables"}, {enable_3, enable_2, enable_1, enable_0}, 0);
      check({tag, "_hbmode"}, {hbridge_mode_23, hbridge_mode_01}, 2'b11);
      check({tag, "_freq"}, pwm_frequency, 20000);
      check({tag, "_update"}, update_config, 0);
      check({tag, "_busy"}, {busy_b, busy_a}, 0);
      check({tag, "_at_target"}, {at_target_b, at_target_a}, 2'b11);
      check({tag, "_fault"}, fault, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      cmd_valid      = 1'b0;
      cmd_motor      = 1'b0;
      cmd_dir        = 1'b0;
      cmd_duty       = '0;
      cfg_valid      = 1'b0;
      cfg_frequency  = '0;
      emergency_stop = 1'b0;
      fault_clear    = 1'b0;
      rst            = 1'b1;
      repeat (3) step();
      check_reset_values("reset");
      rst = 1'b0;
      #1;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_cfg_ready", cfg_ready, 1);

      // Ramp up A forward to 250
      send_cmd(MOTOR_A, DIR_FWD, 16'd250);
      check("ramp_busy_a", busy_a, 1);
      check("ramp_at_target_a_early", at_target_a, 0);
      exp_q.push_back(16'd100);
      exp_q.push_back(16'd200);
      exp_q.push_back(16'd250);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         pop_check("ramp_duty0", duty_cycle_0);
         check("ramp_en1_low", enable_1, 0);
      end
      check("ramp_at_target_a", at_target_a, 1);
      check("ramp_busy_a_done", busy_a, 0);
      check("ramp_en0_high", enable_0, 1);

      // Reversal to A reverse 150
      send_cmd(MOTOR_A, DIR_REV, 16'd150);
      exp_q.push_back(16'd150);
      exp_q.push_back(16'd50);
      exp_q.push_back(16'd0);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         pop_check("decel_duty0", duty_cycle_0);
      end
      cmd_motor = MOTOR_A;
      #1;
      check("coast_state_a", dbg_state_a, ST_COAST);
      check("coast_ready_a_1", cmd_ready, 0);
      check("coast_en_a_1", {enable_1, enable_0}, 0);
      wait_tick();
      check("coast_ready_a_2", cmd_ready, 0);
      check("coast_en_a_2", {enable_1, enable_0}, 0);
      wait_tick();
      check("coast_en_a_3", {enable_1, enable_0}, 0);
      check("coast_end_duty1", duty_cycle_1, 0);
      exp_q.push_back(16'd100);
      exp_q.push_back(16'd150);
      for (int i = 0; i < 2; i++) begin
         wait_tick();
         pop_check("rev_duty1", duty_cycle_1);
         check("rev_duty0_zero", duty_cycle_0, 0);
      end

      // Config gating: refused while motors are running
      send_cmd(MOTOR_B, DIR_FWD, 16'd300);
      exp_q.push_back(16'd100);
      exp_q.push_back(16'd200);
      exp_q.push_back(16'd300);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         pop_check("b_ramp_duty2", duty_cycle_2);
      end
      cfg_frequency = 32'd10000;
      cfg_valid     = 1'b1;
      #1;
      check("cfg_ready_running", cfg_ready, 0);
      step();
      cfg_valid = 1'b0;
      check("cfg_refused_freq", pwm_frequency, 20000);
      check("cfg_refused_update", update_config, 0);
      send_cmd(MOTOR_A, DIR_REV, 16'd0);
      send_cmd(MOTOR_B, DIR_FWD, 16'd0);
      exp_q.push_back(16'd200);
      exp_q.push_back(16'd100);
      exp_q.push_back(16'd0);
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         pop_check("b_down_duty2", duty_cycle_2);
      end
      check("stop_state_a", dbg_state_a, ST_IDLE);
      check("stop_state_b", dbg_state_b, ST_IDLE);
      check("stop_duty1", duty_cycle_1, 0);
      cfg_valid = 1'b1;
      #1;
      check("cfg_ready_idle", cfg_ready, 1);
      step();
      cfg_valid = 1'b0;
      check("cfg_freq", pwm_frequency, 10000);
      check("cfg_update_pulse", update_config, 1);
      step();
      check("cfg_update_single", update_config, 0);
      check("cfg_freq_held", pwm_frequency, 10000);

      // Emergency stop mid-ramp, coinciding with a command
      send_cmd(MOTOR_A, DIR_REV, 16'd500);
      wait_tick();
      check("estop_pre_duty1", duty_cycle_1, 100);
      cmd_motor      = MOTOR_A;
      cmd_dir        = DIR_REV;
      cmd_duty       = 16'd800;
      cmd_valid      = 1'b1;
      emergency_stop = 1'b1;
      #1;
      check("estop_cmd_ready", cmd_ready, 0);
      step();
      emergency_stop = 1'b0;
      check("estop_fault", fault, 1);
      check("estop_duties", {duty_cycle_3, duty_cycle_2, duty_cycle_1, duty_cycle_0}, 0);
      check("estop_enables", {enable_3, enable_2, enable_1, enable_0}, 0);
      check("estop_busy_a", busy_a, 0);
      #1;
      check("fault_cmd_ready", cmd_ready, 0);
      check("fault_cfg_ready", cfg_ready, 0);
      step();
      cmd_valid = 1'b0;
      check("fault_refused_busy", busy_a, 0);
      check("fault_refused_duty1", duty_cycle_1, 0);
      fault_clear = 1'b1;
      step();
      fault_clear = 1'b0;
      check("fault_cleared", fault, 0);
      send_cmd(MOTOR_A, DIR_REV, 16'd200);
      wait_tick();
      check("post_clear_duty1", duty_cycle_1, 100);
      wait_tick();
      check("post_clear_duty1_tgt", duty_cycle_1, 200);
      send_cmd(MOTOR_A, DIR_REV, 16'd0);
      repeat (3) wait_tick();
      check("post_clear_idle", busy_a, 0);

      // Saturation and command coincident with a tick
      while (m_presc != STEP_DIV - 1) step();
      send_cmd(MOTOR_A, DIR_REV, 16'hFFFF);
      check("sim_no_step", duty_cycle_1, 0);
      check("sim_busy", busy_a, 1);
      check("sim_not_at_target", at_target_a, 0);
      wait_tick();
      check("sim_first_step", duty_cycle_1, 100);
      repeat (9) wait_tick();
      check("sat_duty1", duty_cycle_1, 1000);
      check("sat_at_target", at_target_a, 1);
      check("sat_busy", busy_a, 0);

      // Reset in the middle of a deceleration
      send_cmd(MOTOR_A, DIR_FWD, 16'd300);
      wait_tick();
      check("rdecel_duty1", duty_cycle_1, 900);
      check("rdecel_state", dbg_state_a, ST_DECEL);
      rst = 1'b1;
      step();
      check_reset_values("midreset");
      rst = 1'b0;
      send_cmd(MOTOR_A, DIR_FWD, 16'd100);
      wait_tick();
      check("after_reset_duty0", duty_cycle_0, 100);
      check("after_reset_en0", enable_0, 1);
      check("after_reset_duty1", duty_cycle_1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
